// File: rtl/cache_replace_if.sv
// Access/fill handshake between a cache way array and its replacement engine.
// The cache side drives the access qualifiers; the engine returns the victim way.
interface cache_replace_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 6
);
  logic               FlushStage;
  logic               CacheEn;
  logic               LRUWriteEn;
  logic               SetValid;
  logic               InvalidateCache;
  logic [NUMWAYS-1:0] HitWay;
  logic [NUMWAYS-1:0] ValidWay;
  logic [SETLEN-1:0]  PAdrSet;
  logic [NUMWAYS-1:0] VictimWay;

  modport master (
    output FlushStage, CacheEn, LRUWriteEn, SetValid, InvalidateCache,
    output HitWay, ValidWay, PAdrSet,
    input  VictimWay
  );

  modport slave (
    input  FlushStage, CacheEn, LRUWriteEn, SetValid, InvalidateCache,
    input  HitWay, ValidWay, PAdrSet,
    output VictimWay
  );
endinterface

// File: rtl/cache_replace.sv
// Victim-way selection for a set-associative cache: tree pseudo-LRU, per-set
// round-robin or global LFSR random, with invalid ways always filled first.
module cache_replace #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 6,
  parameter int POLICY  = 0
) (
  input logic            clk,
  input logic            reset,
  cache_replace_if.slave bus
);
  localparam int LOGW    = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
  localparam int NUMSETS = 1 << SETLEN;

  logic [NUMWAYS-1:0] invalidVictim;
  logic               anyInvalid;

  always_comb begin
    invalidVictim = '0;
    anyInvalid    = 1'b0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (!bus.ValidWay[i] && !anyInvalid) begin
        invalidVictim[i] = 1'b1;
        anyInvalid       = 1'b1;
      end
    end
  end

  if (NUMWAYS == 1) begin : gDirect
    logic unusedInputs;
    assign unusedInputs  = &{1'b0, bus.FlushStage, bus.CacheEn, bus.SetValid,
                             bus.InvalidateCache, bus.PAdrSet, anyInvalid, invalidVictim};
    assign bus.VictimWay = '1;
  end else begin : gState
    logic [NUMWAYS-1:0] policyVictim;

    assign bus.VictimWay = anyInvalid ? invalidVictim : policyVictim;

    if (POLICY == 0) begin : gPlru
      logic               updateEn;
      logic [NUMWAYS-1:0] accessedWay;
      logic [LOGW-1:0]    accessedIdx;
      logic [NUMWAYS-2:0] treeCur;
      logic [NUMWAYS-2:0] treeNext;
      logic [NUMWAYS-2:0] treeRows [NUMSETS];
      logic               unusedInputs;

      assign unusedInputs = &{1'b0, bus.CacheEn, bus.SetValid};
      assign updateEn     = bus.LRUWriteEn & ~bus.FlushStage & ~bus.InvalidateCache;
      assign accessedWay  = (|bus.HitWay) ? bus.HitWay : bus.VictimWay;
      assign treeCur      = treeRows[bus.PAdrSet];

      always_comb begin
        accessedIdx = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
          if (accessedWay[i]) accessedIdx = accessedIdx | LOGW'(i);
        end
      end

      // A leaf is the victim when every node on its path points toward it.
      for (genvar gi = 0; gi < NUMWAYS; gi++) begin : gLeaf
        logic [LOGW-1:0] pathMatch;
        for (genvar gl = 0; gl < LOGW; gl++) begin : gLvl
          localparam int   NODE  = ((1 << gl) - 1) + (gi >> (LOGW - gl));
          localparam logic UPPER = 1'((gi >> (LOGW - 1 - gl)) & 1);
          assign pathMatch[gl] = (treeCur[NODE] == UPPER);
        end
        assign policyVictim[gi] = &pathMatch;
      end

      // Nodes on the accessed path flip to point at the opposite subtree.
      for (genvar gi = 0; gi < NUMWAYS - 1; gi++) begin : gNode
        localparam int LVL = $clog2(gi + 2) - 1;
        localparam int POS = gi - ((1 << LVL) - 1);
        logic onPath;
        assign onPath       = ((accessedIdx >> (LOGW - LVL)) == LOGW'(POS));
        assign treeNext[gi] = onPath ? ~accessedIdx[LOGW-1-LVL] : treeCur[gi];
      end

      for (genvar gi = 0; gi < NUMSETS; gi++) begin : gSet
        logic [NUMWAYS-2:0] treeReg;
        always_ff @(posedge clk) begin
          if (reset || bus.InvalidateCache) begin
            treeReg <= '0;
          end else if (updateEn && (bus.PAdrSet == SETLEN'(gi))) begin
            treeReg <= treeNext;
          end
        end
        assign treeRows[gi] = treeReg;
      end
    end else if (POLICY == 1) begin : gRoundRobin
      logic            advanceEn;
      logic [LOGW-1:0] ptrCur;
      logic [LOGW-1:0] ptrRows [NUMSETS];
      logic            unusedInputs;

      assign unusedInputs = &{1'b0, bus.CacheEn};
      // Only fills on a miss consume the pointer; hits leave it alone.
      assign advanceEn = bus.LRUWriteEn & ~bus.FlushStage & ~bus.InvalidateCache
                       & bus.SetValid & ~(|bus.HitWay);
      assign ptrCur    = ptrRows[bus.PAdrSet];

      always_comb begin
        policyVictim         = '0;
        policyVictim[ptrCur] = 1'b1;
      end

      for (genvar gi = 0; gi < NUMSETS; gi++) begin : gSet
        logic [LOGW-1:0] ptrReg;
        always_ff @(posedge clk) begin
          if (reset || bus.InvalidateCache) begin
            ptrReg <= '0;
          end else if (advanceEn && (bus.PAdrSet == SETLEN'(gi))) begin
            ptrReg <= ptrReg + LOGW'(1);
          end
        end
        assign ptrRows[gi] = ptrReg;
      end
    end else begin : gRandom
      logic [15:0] lfsrReg;
      logic        unusedInputs;

      assign unusedInputs = &{1'b0, bus.FlushStage, bus.SetValid,
                              bus.InvalidateCache, bus.PAdrSet};

      // Free-running while the array is enabled; flushes and invalidates do not touch it.
      always_ff @(posedge clk) begin
        if (reset) begin
          lfsrReg <= 16'h0001;
        end else if (bus.CacheEn) begin
          lfsrReg <= {1'b0, lfsrReg[15:1]} ^ (lfsrReg[0] ? 16'hB400 : 16'h0000);
        end
      end

      always_comb begin
        policyVictim                     = '0;
        policyVictim[lfsrReg[LOGW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.LRUWriteEn) begin
      assert ($onehot0(bus.HitWay))
        else $error("cache_replace: multi-hot HitWay %b", bus.HitWay);
    end
  end
endmodule

// File: tb/tb_cache_replace.sv
// Scoreboard bench: one DUT per replacement policy, shared stimulus, expected
// victims queued from a behavioural model plus hand-derived directed values.
module tb_cache_replace;
  localparam int W    = 4;
  localparam int LW   = 2;
  localparam int SL   = 6;
  localparam int NS   = 1 << SL;

  typedef struct {
    string        tag;
    int           dut;
    logic [W-1:0] want;
  } expT;

  logic          clk = 1'b0;
  logic          reset;
  logic          flushStage, cacheEn, lruWriteEn, setValid, invalidateCache;
  logic [W-1:0]  hitWay, validWay;
  logic [SL-1:0] padrSet;

  int            compared   = 0;
  int            mismatched = 0;
  expT           sbQ[$];

  logic [W-2:0]  mTree [NS];
  logic [LW-1:0] mPtr  [NS];
  logic [15:0]   mLfsr;

  always #5 clk = ~clk;

  cache_replace_if #(.NUMWAYS(W), .SETLEN(SL)) busP ();
  cache_replace_if #(.NUMWAYS(W), .SETLEN(SL)) busR ();
  cache_replace_if #(.NUMWAYS(W), .SETLEN(SL)) busX ();

  assign busP.FlushStage = flushStage;      assign busR.FlushStage = flushStage;      assign busX.FlushStage = flushStage;
  assign busP.CacheEn = cacheEn;            assign busR.CacheEn = cacheEn;            assign busX.CacheEn = cacheEn;
  assign busP.LRUWriteEn = lruWriteEn;      assign busR.LRUWriteEn = lruWriteEn;      assign busX.LRUWriteEn = lruWriteEn;
  assign busP.SetValid = setValid;          assign busR.SetValid = setValid;          assign busX.SetValid = setValid;
  assign busP.InvalidateCache = invalidateCache;
  assign busR.InvalidateCache = invalidateCache;
  assign busX.InvalidateCache = invalidateCache;
  assign busP.HitWay = hitWay;              assign busR.HitWay = hitWay;              assign busX.HitWay = hitWay;
  assign busP.ValidWay = validWay;          assign busR.ValidWay = validWay;          assign busX.ValidWay = validWay;
  assign busP.PAdrSet = padrSet;            assign busR.PAdrSet = padrSet;            assign busX.PAdrSet = padrSet;

  cache_replace #(.NUMWAYS(W), .SETLEN(SL), .POLICY(0)) dutPlru (.clk(clk), .reset(reset), .bus(busP.slave));
  cache_replace #(.NUMWAYS(W), .SETLEN(SL), .POLICY(1)) dutRr   (.clk(clk), .reset(reset), .bus(busR.slave));
  cache_replace #(.NUMWAYS(W), .SETLEN(SL), .POLICY(2)) dutRand (.clk(clk), .reset(reset), .bus(busX.slave));

  logic [W-1:0] victims [3];
  assign victims[0] = busP.VictimWay;
  assign victims[1] = busR.VictimWay;
  assign victims[2] = busX.VictimWay;

  task automatic checkVal(string tag, logic [W-1:0] got, logic [W-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] lowInvalid(logic [W-1:0] v);
    for (int i = 0; i < W; i++) begin
      if (!v[i]) return W'(1) << i;
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] modelVictim(int d);
    logic [W-1:0] inv;
    logic [W-2:0] t;
    int           node;
    inv = lowInvalid(validWay);
    if (inv != '0) return inv;
    if (d == 0) begin
      t    = mTree[padrSet];
      node = 0;
      for (int l = 0; l < LW; l++) node = t[node] ? 2 * node + 2 : 2 * node + 1;
      return W'(1) << (node - (W - 1));
    end else if (d == 1) begin
      return W'(1) << mPtr[padrSet];
    end
    return W'(1) << mLfsr[LW-1:0];
  endfunction

  task automatic modelClear();
    for (int s = 0; s < NS; s++) begin
      mTree[s] = '0;
      mPtr[s]  = '0;
    end
  endtask

  // Applies what the rising edge does to every model, from pre-edge values.
  task automatic modelEdge();
    logic [W-1:0] acc;
    int           idx;
    int           node;
    int           dir;
    if (reset) begin
      modelClear();
      mLfsr = 16'h0001;
      return;
    end
    if (cacheEn) mLfsr = (mLfsr >> 1) ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
    if (invalidateCache) begin
      modelClear();
    end else if (lruWriteEn && !flushStage) begin
      acc = (hitWay != '0) ? hitWay : modelVictim(0);
      idx = 0;
      for (int i = 0; i < W; i++) if (acc[i]) idx = i;
      node = 0;
      for (int l = 0; l < LW; l++) begin
        dir                    = (idx >> (LW - 1 - l)) & 1;
        mTree[padrSet][node]   = (dir == 0);
        node                   = 2 * node + 1 + dir;
      end
      if (setValid && hitWay == '0) mPtr[padrSet] = mPtr[padrSet] + 1'b1;
    end
  endtask

  task automatic expectVictim(string tag, int d, logic [W-1:0] want);
    sbQ.push_back('{tag: tag, dut: d, want: want});
  endtask

  task automatic cycle();
    expT e;
    for (int d = 0; d < 3; d++) expectVictim("model", d, modelVictim(d));
    @(negedge clk);
    $display("cyc rst=%0d set=%0d lru=%0d hit=%b valid=%b sv=%0d fl=%0d inv=%0d en=%0d victims P=%b R=%b X=%b",
             reset, padrSet, lruWriteEn, hitWay, validWay, setValid, flushStage, invalidateCache,
             cacheEn, victims[0], victims[1], victims[2]);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal($sformatf("%s/dut%0d/set%0d", e.tag, e.dut, padrSet), victims[e.dut], e.want);
    end
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    flushStage      = 1'b0;
    cacheEn         = 1'b0;
    lruWriteEn      = 1'b0;
    setValid        = 1'b0;
    invalidateCache = 1'b0;
    hitWay          = '0;
    validWay        = '1;
  endtask

  initial begin
    setIdle();
    padrSet = SL'(3);
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelEdge();

    // Reset state of all three policies
    expectVictim("rstPlru", 0, 4'b0001);
    expectVictim("rstRr",   1, 4'b0001);
    expectVictim("rstRand", 2, 4'b0010);
    cycle();
    reset = 1'b0;

    // PLRU hit sequence on set 3
    lruWriteEn = 1'b1; hitWay = 4'b0001;
    cycle();
    hitWay = 4'b0100;
    expectVictim("plruAfterHit0", 0, 4'b0100);
    cycle();
    setIdle();
    expectVictim("plruAfterHit2", 0, 4'b0010);
    cycle();

    // Flushed access leaves state alone
    lruWriteEn = 1'b1; flushStage = 1'b1; hitWay = 4'b0001;
    cycle();
    setIdle();
    expectVictim("plruFlushHold", 0, 4'b0010);
    cycle();

    // Invalid way wins over any policy
    validWay = 4'b1011;
    for (int d = 0; d < 3; d++) expectVictim("invalidOverride", d, 4'b0100);
    cycle();

    // Invalidate beats a concurrent update
    setIdle();
    invalidateCache = 1'b1; lruWriteEn = 1'b1; hitWay = 4'b0001;
    cycle();
    setIdle();
    expectVictim("plruInvalidated", 0, 4'b0001);
    cycle();

    // Round-robin: three miss fills on set 5, neighbour untouched
    padrSet = SL'(5); lruWriteEn = 1'b1; setValid = 1'b1;
    repeat (3) cycle();
    setIdle();
    expectVictim("rrSet5", 1, 4'b1000);
    cycle();
    lruWriteEn = 1'b1; setValid = 1'b1; hitWay = 4'b0010;
    cycle();
    setIdle();
    expectVictim("rrHitNoAdvance", 1, 4'b1000);
    cycle();
    padrSet = SL'(6);
    expectVictim("rrSet6", 1, 4'b0001);
    cycle();

    // Reset during an access wins
    padrSet = SL'(5); lruWriteEn = 1'b1; setValid = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0;
    setIdle();
    expectVictim("rstOverridePlru", 0, 4'b0001);
    expectVictim("rstOverrideRr",   1, 4'b0001);
    expectVictim("rstOverrideRand", 2, 4'b0010);
    cycle();

    // Random: one LFSR step 0x0001 -> 0xB400
    cacheEn = 1'b1;
    cycle();
    setIdle();
    expectVictim("randStep", 2, 4'b0001);
    cycle();

    // Randomised traffic against the models
    for (int n = 0; n < 300; n++) begin
      padrSet         = SL'($urandom_range(0, 3));
      lruWriteEn      = ($urandom_range(0, 3) != 0);
      hitWay          = ($urandom_range(0, 1) != 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      setValid        = (hitWay == '0) && ($urandom_range(0, 1) != 0);
      flushStage      = ($urandom_range(0, 7) == 0);
      invalidateCache = ($urandom_range(0, 31) == 0);
      cacheEn         = ($urandom_range(0, 1) != 0);
      validWay        = ($urandom_range(0, 5) == 0) ? W'($urandom) : '1;
      reset           = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cache_replace.md
CACHE_REPLACE -- requirements
Module: cache_replace

Interface
REQ-001 SHALL have parameter NUMWAYS, default 4, ways per set; a power of two, 1 to 16.
REQ-002 SHALL have parameter SETLEN, default 6, set-index width; sets = 2**SETLEN.
REQ-003 SHALL have parameter POLICY, default 0: 0 = tree pseudo-LRU, 1 = per-set round-robin, 2 = LFSR random.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port FlushStage, input, 1, pipeline flush; suppresses state updates this cycle.
REQ-007 SHALL have port CacheEn, input, 1, cache array enable; steps the LFSR.
REQ-008 SHALL have port LRUWriteEn, input, 1, access completing this cycle; requests a state update.
REQ-009 SHALL have port SetValid, input, 1, line fill into the victim way this cycle.
REQ-010 SHALL have port InvalidateCache, input, 1, clear all replacement state.
REQ-011 SHALL have port HitWay, input, NUMWAYS, one-hot hit vector (all zero on miss).
REQ-012 SHALL have port ValidWay, input, NUMWAYS, valid bits of the addressed set.
REQ-013 SHALL have port PAdrSet, input, SETLEN, set index of the current access.
REQ-014 SHALL have port VictimWay, output, NUMWAYS, one-hot way chosen for replacement.

Function
REQ-015 VictimWay SHALL be combinational from the current-cycle inputs and the stored state; it is always exactly one-hot.
REQ-016 If any ValidWay bit is 0, VictimWay SHALL be the lowest-index invalid way, for every POLICY.
REQ-017 With NUMWAYS=1, VictimWay SHALL be constant 1 and no state SHALL be instantiated.
REQ-018 Accessed way SHALL be HitWay when HitWay is nonzero, else VictimWay.
REQ-019 Update condition U SHALL be LRUWriteEn & ~FlushStage & ~InvalidateCache.
REQ-020 PLRU: each set SHALL store NUMWAYS-1 tree bits, node 0 = root, node i children = 2i+1 (lower ways) and 2i+2 (upper ways).
REQ-021 PLRU victim SHALL be found by walking from the root: bit 1 goes to the upper child, bit 0 goes to the lower child.
REQ-022 PLRU on U: each node on the accessed way's path SHALL be set to point away from it (1 if the way is in the lower subtree, 0 if upper); all other nodes are unchanged.
REQ-023 Round-robin: each set SHALL store a log2(NUMWAYS)-bit pointer; victim = one-hot(pointer).
REQ-024 Round-robin pointer SHALL advance by 1 mod NUMWAYS only on U & SetValid & (HitWay==0); hits SHALL NOT advance it.
REQ-025 Random: SHALL use one global 16-bit Galois LFSR, right-shifting, taps mask 0xB400.
REQ-026 Random: the LFSR SHALL step once per cycle with CacheEn=1, regardless of FlushStage; victim = one-hot(LFSR[log2(NUMWAYS)-1:0]).
REQ-027 Only the set addressed by PAdrSet SHALL be modified; all other sets hold.
REQ-028 A state write to set S SHALL be visible to VictimWay for set S on the following cycle; there is no same-cycle bypass.
REQ-029 InvalidateCache SHALL zero all per-set state (PLRU bits, RR pointers) at the next edge, taking priority over U; the LFSR SHALL be unaffected.
REQ-030 ValidWay and HitWay values other than one-hot/zero HitWay are illegal; a simulation assertion SHALL flag multi-hot HitWay when LRUWriteEn=1.

Reset
REQ-031 On reset, all PLRU bits and RR pointers SHALL be 0, and the LFSR SHALL be 0x0001.
REQ-032 After reset, with all ways valid, VictimWay SHALL be way 0 for PLRU and RR, and way (0x0001 mod NUMWAYS) for random.
REQ-033 Reset asserted during any access SHALL override U and InvalidateCache; no partial update survives.

Verification
REQ-034 PLRU, 4 ways, set 3, all valid: hit way0 (0001) with LRUWriteEn -> next cycle VictimWay=0100; then hit way2 -> VictimWay=0010.
REQ-035 RR, 4 ways: three misses with SetValid and LRUWriteEn on set 5 -> set 5 VictimWay=1000, set 6 VictimWay=0001.
REQ-036 Random, 4 ways, after reset -> VictimWay=0010; one CacheEn cycle (LFSR becomes 0xB400) -> VictimWay=0001.
REQ-037 Any POLICY: ValidWay=1011 -> VictimWay=0100 regardless of stored state.
REQ-038 PLRU: hit with LRUWriteEn=1 and FlushStage=1 -> state unchanged; LRUWriteEn together with InvalidateCache -> all sets return to victim way 0.
